// File: rtl/banked_memory_model_if.sv
// Bus between the cache arbiter and the banked main-memory model: request
// side (addr/read/write/wdata) and the ready/read-return side.
interface banked_memory_model_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid
    );

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid
    );
endinterface

// File: rtl/banked_memory_model.sv
// Line-oriented main-memory model. Write bursts commit one beat per edge;
// reads are queued with a fixed latency and returned as in-order bursts
// read straight from storage in the cycle each beat is presented.
module banked_memory_model #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LEN    = 4,
    parameter int LINE_COUNT   = 256,
    parameter int READ_LATENCY = 8,
    parameter int QUEUE_DEPTH  = 4
) (
    input logic                 clk,
    input logic                 rst,
    banked_memory_model_if.slave bus
);
    localparam int OFF_W  = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(LINE_COUNT);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    // Storage is deliberately never reset: contents survive rst.
    logic [DATA_WIDTH-1:0] mem [LINE_COUNT * BURST_LEN];

    logic                    out_of_reset;
    logic                    wr_busy;
    logic [BEAT_W-1:0]       wr_beat;
    logic [IDX_W-1:0]        wr_idx;

    logic [LINE_W-1:0]       q_line [QUEUE_DEPTH];
    logic [LAT_W-1:0]        q_cnt  [QUEUE_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    logic [BEAT_W-1:0]       rd_beat;

    logic                    wr_accept;
    logic                    rd_accept;
    logic                    head_due;
    logic                    pop;
    logic                    mem_we;
    logic [IDX_W+BEAT_W-1:0] mem_waddr;
    logic [IDX_W-1:0]        rd_idx;

    // Byte-offset bits of the request address carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[OFF_W-1:0];

    assign bus.ready = out_of_reset && (count < CNT_W'(QUEUE_DEPTH)) && !wr_busy;
    // A write on the same cycle as a read wins; the read is simply not queued.
    assign wr_accept = bus.write && bus.ready;
    assign rd_accept = bus.read && bus.ready && !bus.write;

    assign head_due = (count != '0) && (q_cnt[head] == '0);
    assign pop      = head_due && (rd_beat == LAST_BEAT);
    assign rd_idx   = q_line[head][IDX_W-1:0];

    assign bus.rvalid = head_due;
    assign bus.raddr  = head_due ? {q_line[head], OFF_W'(0)} : '0;
    assign bus.rdata  = head_due ? mem[{rd_idx, rd_beat}] : '0;

    // ready is held low for the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_of_reset <= 1'b0;
        else      out_of_reset <= 1'b1;
    end

    // Write burst sequencing: beat 0 at accept, then BURST_LEN-1 busy beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_busy <= 1'b0;
            wr_beat <= '0;
        end else if (wr_accept) begin
            wr_busy <= 1'b1;
            wr_beat <= BEAT_W'(1);
        end else if (wr_busy) begin
            wr_beat <= wr_beat + 1'b1;
            if (wr_beat == LAST_BEAT) wr_busy <= 1'b0;
        end
    end

    // Line index of the write burst is latched once at accept.
    always_ff @(posedge clk) begin
        if (wr_accept) wr_idx <= bus.addr[OFF_W +: IDX_W];
    end

    // Select which storage word the current write beat lands in.
    always_comb begin
        mem_we    = wr_accept || wr_busy;
        mem_waddr = {bus.addr[OFF_W +: IDX_W], BEAT_W'(0)};
        if (wr_busy) mem_waddr = {wr_idx, wr_beat};
    end

    // Each write beat commits at its own edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= bus.wdata;
    end

    // Read queue control: per-entry countdowns, push/pop, beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_beat <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) q_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
            end
            if (rd_accept) begin
                q_cnt[tail] <= LAT_W'(READ_LATENCY);
                tail        <= tail + 1'b1;
            end
            if (head_due) begin
                if (rd_beat == LAST_BEAT) begin
                    rd_beat <= '0;
                    head    <= head + 1'b1;
                end else begin
                    rd_beat <= rd_beat + 1'b1;
                end
            end
            case ({rd_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Line-aligned address of each queued read.
    always_ff @(posedge clk) begin
        if (rd_accept) q_line[tail] <= bus.addr[ADDR_WIDTH-1:OFF_W];
    end
endmodule

// File: tb/tb_banked_memory_model.sv
// Scoreboard bench for banked_memory_model: stimulus pushes expected beats
// (cycle, raddr, rdata) into a queue; a negedge monitor pops and compares.
module tb_banked_memory_model;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_memory_model_if bif ();

    banked_memory_model dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [63:0] d;
    } exp_t;
    exp_t sbq[$];

    logic [63:0] mdl [256][4];
    int last_end = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t e;
    always @(negedge clk) begin
        if (bif.rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got raddr %h at cycle %0d want no beat", bif.raddr, cyc);
            end else begin
                e = sbq.pop_front();
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
                chk("raddr", 64'(bif.raddr), 64'(e.a));
                chk("rdata", bif.rdata, e.d);
            end
        end else begin
            chk("idle_raddr", 64'(bif.raddr), 64'd0);
            chk("idle_rdata", bif.rdata, 64'd0);
            if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_beat: got rvalid 0 at cycle %0d want beat raddr %h", cyc, sbq[0].a);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bif.read  = 1'b0;
            bif.write = 1'b0;
        end
    endtask

    task automatic rd(input logic [31:0] a, output int acc);
        int idx;
        int st;
        @(negedge clk);
        bif.read  = 1'b1;
        bif.write = 1'b0;
        bif.addr  = a;
        acc = cyc + 1;
        chk("read_ready", 64'(bif.ready), 64'd1);
        if (bif.ready === 1'b1) begin
            idx = int'((a >> 5) & 32'hFF);
            st  = (acc + 8 > last_end + 1) ? acc + 8 : last_end + 1;
            for (int k = 0; k < 4; k++) begin
                exp_t x;
                x.cyc = st + k;
                x.a   = a & ~32'h1F;
                x.d   = mdl[idx][k];
                sbq.push_back(x);
            end
            last_end = st + 3;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [63:0] d3, input bit with_read);
        logic [63:0] d [4];
        int idx;
        d   = '{d0, d1, d2, d3};
        idx = int'((a >> 5) & 32'hFF);
        @(negedge clk);
        bif.write = 1'b1;
        bif.read  = with_read;
        bif.addr  = a;
        bif.wdata = d[0];
        chk("write_ready", 64'(bif.ready), 64'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            bif.read  = 1'b0;
            bif.addr  = 32'hDEAD_BEE0;
            bif.wdata = d[k];
            chk("write_busy_ready", 64'(bif.ready), 64'd0);
        end
        for (int k = 0; k < 4; k++) mdl[idx][k] = d[k];
    endtask

    int a1;
    int acc;

    initial begin
        bif.addr  = '0;
        bif.read  = 1'b0;
        bif.write = 1'b0;
        bif.wdata = '0;
        #1 rst = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bif.ready), 64'd0);
        chk("rst_rvalid", 64'(bif.rvalid), 64'd0);
        chk("rst_raddr", 64'(bif.raddr), 64'd0);
        chk("rst_rdata", bif.rdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(bif.ready), 64'd1);

        // Write then read, then unaligned and alias reads
        wr(32'h0000_1040, 64'h11, 64'h22, 64'h33, 64'h44, 1'b0);
        rd(32'h0000_1040, acc);
        idle(14);
        rd(32'h0000_105C, acc);
        idle(14);
        rd(32'h0000_3040, acc);
        idle(14);

        // Read and write together: write wins, no response for the read
        wr(32'h0000_0080, 64'hA1A1_0000_0000_0001, 64'hB2B2_0000_0000_0002,
           64'hC3C3_0000_0000_0003, 64'hD4D4_0000_0000_0004, 1'b1);
        idle(14);
        rd(32'h0000_0080, acc);
        idle(14);

        // Four back-to-back reads: full queue, gapless in-order return
        rd(32'h0000_1040, a1);
        rd(32'h0000_0080, acc);
        rd(32'h0000_3040, acc);
        rd(32'h0000_105C, acc);
        @(negedge clk);
        bif.read = 1'b0;
        chk("full_ready", 64'(bif.ready), 64'd0);
        while (cyc < a1 + 11) @(negedge clk);
        chk("ready_last_beat", 64'(bif.ready), 64'd0);
        @(negedge clk);
        chk("ready_after_pop", 64'(bif.ready), 64'd1);
        idle(20);

        // Reset in the middle of a pending read
        rd(32'h0000_0080, acc);
        idle(1);
        while (cyc < acc + 2) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        last_end = -100;
        @(negedge clk);
        chk("midrst_ready", 64'(bif.ready), 64'd0);
        @(negedge clk);
        chk("midrst_rvalid", 64'(bif.rvalid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 64'(bif.ready), 64'd1);
        idle(20);

        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending want 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
